// File: rtl/serial_frame_tx_pkg.sv
// Shared definitions for the serial frame transmitter.
//   state_t    : 2-bit frame state encoding (IDLE/START/DATA/STOP)
//   START_LVL  : line level of the start bit
//   IDLE_LVL   : line level when idle and during stop bits
//   cnt_w()    : counter width for a 0..range-1 counter, never below 1 bit
package serial_frame_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_START = 2'b01,
    ST_DATA  = 2'b10,
    ST_STOP  = 2'b11
  } state_t;

  localparam logic START_LVL = 1'b1;
  localparam logic IDLE_LVL  = 1'b0;

  function automatic int cnt_w(input int range);
    return (range > 1) ? $clog2(range) : 1;
  endfunction

endpackage

// File: rtl/serial_frame_tx_bit_timer.sv
// Per-bit cycle counter. Counts 0..CLKS_PER_BIT-1 and flags the last cycle
// of each bit period.
//   clk      : clock
//   rst_n    : asynchronous active-low reset
//   clear    : hold the count at 0 (used while the transmitter is idle)
//   bit_end  : high on the final cycle of the current bit period
module serial_frame_tx_bit_timer
  import serial_frame_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic bit_end
);

  localparam int            CW   = cnt_w(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear || bit_end) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  // With CLKS_PER_BIT=1 the count is pinned at 0, so every cycle is a bit end.
  assign bit_end = (cnt == LAST);

endmodule

// File: rtl/serial_frame_tx.sv
// Parallel-to-serial frame transmitter: start bit (1), DATA_W data bits MSB
// first, STOP_BITS stop bits (0). Line idles low.
//   clk        : clock
//   rst_n      : asynchronous active-low reset
//   in_valid   : producer offers in_data
//   in_data    : word to send, sampled only on accept
//   in_ready   : block can accept a word this cycle
//   serial_out : serial line
//   busy       : frame in progress
//   done       : one-cycle pulse in the first idle cycle after a frame
//
// state    | meaning
// ---------+--------------------------------------------
// ST_IDLE  | line low, ready for a word
// ST_START | driving the start bit for one bit period
// ST_DATA  | shifting data out MSB first, one bit period each
// ST_STOP  | driving STOP_BITS low bit periods
module serial_frame_tx
  import serial_frame_tx_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4,
  parameter int STOP_BITS    = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              serial_out,
  output logic              busy,
  output logic              done
);

  localparam int            BW        = cnt_w(DATA_W);
  localparam int            SW        = cnt_w(STOP_BITS);
  localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_W - 1);
  localparam logic [SW-1:0] LAST_STOP = SW'(STOP_BITS - 1);

  state_t            state_q;
  state_t            state_d;
  logic [DATA_W-1:0] shreg;
  logic [BW-1:0]     bit_idx;
  logic [SW-1:0]     stop_idx;
  logic              bit_end;
  logic              timer_clear;
  logic              accept;
  logic              last_bit;
  logic              last_stop;

  assign accept    = in_valid & in_ready;
  assign last_bit  = (bit_idx == LAST_BIT);
  assign last_stop = (stop_idx == LAST_STOP);

  // Holding the timer clear in IDLE makes the count start at 0 on accept.
  assign timer_clear = (state_q == ST_IDLE);

  serial_frame_tx_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (timer_clear),
    .bit_end(bit_end)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (accept)                state_d = ST_START;
      ST_START: if (bit_end)               state_d = ST_DATA;
      ST_DATA:  if (bit_end && last_bit)   state_d = ST_STOP;
      ST_STOP:  if (bit_end && last_stop)  state_d = ST_IDLE;
      default:                             state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    serial_out = IDLE_LVL;
    in_ready   = 1'b0;
    case (state_q)
      ST_IDLE:  in_ready   = 1'b1;
      ST_START: serial_out = START_LVL;
      ST_DATA:  serial_out = shreg[DATA_W-1];
      ST_STOP:  serial_out = IDLE_LVL;
      default:  in_ready   = 1'b1;
    endcase
  end

  assign busy = !in_ready;

  // Datapath: shift register, bit/stop indices and the registered done pulse.
  // Indices stop at their last value rather than wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg    <= '0;
      bit_idx  <= '0;
      stop_idx <= '0;
      done     <= 1'b0;
    end else begin
      done <= (state_q == ST_STOP) && bit_end && last_stop;
      case (state_q)
        ST_IDLE: begin
          if (accept) shreg <= in_data;
        end
        ST_START: begin
          if (bit_end) bit_idx <= '0;
        end
        ST_DATA: begin
          if (bit_end) begin
            shreg <= shreg << 1;
            if (last_bit) stop_idx <= '0;
            else          bit_idx  <= bit_idx + BW'(1);
          end
        end
        ST_STOP: begin
          if (bit_end && !last_stop) stop_idx <= stop_idx + SW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_frame_tx.sv
module tb_serial_frame_tx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = '0;
  logic       in_ready, serial_out, busy, done;

  logic       v2 = 1'b0;
  logic [3:0] d2 = '0;
  logic       r2, so2, busy2, done2;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  serial_frame_tx #(.DATA_W(8), .CLKS_PER_BIT(4), .STOP_BITS(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .serial_out(serial_out), .busy(busy), .done(done)
  );

  serial_frame_tx #(.DATA_W(4), .CLKS_PER_BIT(1), .STOP_BITS(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(v2), .in_data(d2),
    .in_ready(r2), .serial_out(so2), .busy(busy2), .done(done2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference line level for cycle i after accept: 4 cycles per slot,
  // slot 0 start, slots 1..8 data MSB first, slot 9 stop.
  function automatic logic exp_line(input logic [7:0] w, input int i);
    int slot;
    slot = i / 4;
    if (slot == 0) return 1'b1;
    if (slot <= 8) return w[8 - slot];
    return 1'b0;
  endfunction

  task automatic offer(input logic [7:0] w);
    @(negedge clk);
    chk("idle_line", serial_out, 0);
    chk("idle_done", done, 0);
    chk("idle_ready", in_ready, 1);
    in_valid = 1'b1;
    in_data  = w;
    @(posedge clk);
  endtask

  // Called just after the accept edge; returns at the negedge of the done cycle.
  task automatic frame_body(input logic [7:0] w, input bit noise, input bit chain,
                            input logic [7:0] next_w);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      chk("line", serial_out, exp_line(w, i));
      chk("busy", busy, 1);
      chk("ready_low", in_ready, 0);
      chk("done_low", done, 0);
      in_valid = noise ? (i < 20) : 1'b0;
      in_data  = noise ? 8'h3C : 8'($urandom);
      if (chain && i == 39) begin
        in_valid = 1'b1;
        in_data  = next_w;
      end
    end
    @(negedge clk);
    chk("done_pulse", done, 1);
    chk("done_ready", in_ready, 1);
    chk("done_line", serial_out, 0);
    chk("done_busy", busy, 0);
    if (!chain) in_valid = 1'b0;
  endtask

  task automatic frame2(input logic [3:0] w);
    @(negedge clk);
    chk("t6_ready", r2, 1);
    v2 = 1'b1;
    d2 = w;
    @(posedge clk);
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      v2 = 1'b0;
      if (i == 0)      chk("t6_line", so2, 1);
      else if (i <= 4) chk("t6_line", so2, w[4 - i]);
      else             chk("t6_line", so2, 0);
      chk("t6_done_low", done2, 0);
    end
    @(negedge clk);
    chk("t6_done", done2, 1);
    @(negedge clk);
    chk("t6_done_clr", done2, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] w, nx;
    bit chain, noise;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_line", serial_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ready", in_ready, 1);

    // Single frame A5
    offer(8'hA5);
    frame_body(8'hA5, 1'b0, 1'b0, 8'h00);

    // Back-to-back FF then 00
    offer(8'hFF);
    frame_body(8'hFF, 1'b0, 1'b1, 8'h00);
    @(posedge clk);
    frame_body(8'h00, 1'b0, 1'b0, 8'h00);

    // in_valid with 3C while busy is ignored
    offer(8'hA5);
    frame_body(8'hA5, 1'b1, 1'b0, 8'h00);
    @(negedge clk);
    chk("noise_one_done", done, 0);
    chk("noise_idle", busy, 0);

    // Reset during data bit 3 of A5
    offer(8'hA5);
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      chk("pre_rst_line", serial_out, exp_line(8'hA5, i));
    end
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_line", serial_out, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("post_rst_done", done, 0);
      chk("post_rst_ready", in_ready, 1);
    end
    offer(8'h81);
    frame_body(8'h81, 1'b0, 1'b0, 8'h00);

    // Randomized frames: random words, noise, chaining and idle gaps
    w = 8'($urandom);
    offer(w);
    for (int k = 0; k < 25; k++) begin
      chain = ($urandom_range(0, 2) == 0);
      noise = ($urandom_range(0, 2) == 0);
      nx    = 8'($urandom);
      frame_body(w, noise, chain, nx);
      if (chain) begin
        @(posedge clk);
        w = nx;
      end else begin
        repeat ($urandom_range(0, 3)) begin
          @(negedge clk);
          chk("gap_line", serial_out, 0);
        end
        w = 8'($urandom);
        offer(w);
      end
    end
    frame_body(w, 1'b0, 1'b0, 8'h00);

    // Narrow instance: DATA_W=4, CLKS_PER_BIT=1, STOP_BITS=2
    frame2(4'b1001);
    for (int k = 0; k < 6; k++) frame2(4'($urandom));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
